// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Brief    : Bundle of ID/EX hazard inputs and stall/flush controls exchanged
//             between the pipeline datapath and the hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1_i;
   logic [4:0]       id_rs2_i;
   logic             id_uses_rs2_i;
   logic [4:0]       ex_rd_i;
   logic             ex_memread_i;
   logic             ex_branch_taken_i;
   logic             mem_req_i;
   logic             mem_ready_i;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             pipe_freeze_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   // Datapath side: supplies hazard information, consumes controls.
   modport master (
      output id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_rd_i, ex_memread_i,
             ex_branch_taken_i, mem_req_i, mem_ready_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
             pipe_freeze_o, stall_cnt_o, flush_cnt_o
   );

   // Controller side.
   modport slave (
      input  id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_rd_i, ex_memread_i,
             ex_branch_taken_i, mem_req_i, mem_ready_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
             pipe_freeze_o, stall_cnt_o, flush_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush generator for a 5-stage pipeline: load-use bubbles,
//             taken-branch squash, data-memory wait freeze, and saturating
//             stall/flush performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int LU_BUBBLES = 1,   // 1..7
   parameter int BR_EXTRA   = 0,   // 0..3
   parameter int CNT_W      = 16
) (
   input wire clk,
   input wire reset,               // asynchronous, active low
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [1:0]       S_RUN       = 2'd0;
   localparam logic [1:0]       S_LU_WAIT   = 2'd1;
   localparam logic [1:0]       S_BR_SQUASH = 2'd2;
   localparam logic [2:0]       C_LU_LOAD   = 3'(LU_BUBBLES - 1);
   localparam logic [2:0]       C_BR_LOAD   = 3'(BR_EXTRA);
   localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic w_freeze, w_branch, w_hz;
   logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush, w_pipe_freeze;

   // Freeze outranks everything; a branch is only accepted when not frozen.
   assign w_freeze = bus.mem_req_i & ~bus.mem_ready_i;
   assign w_branch = bus.ex_branch_taken_i & ~w_freeze;
   assign w_hz     = bus.ex_memread_i & (bus.ex_rd_i != 5'd0) &
                     ((bus.ex_rd_i == bus.id_rs1_i) |
                      (bus.id_uses_rs2_i & (bus.ex_rd_i == bus.id_rs2_i)));

   // State and bubble/squash down-counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: branch redirects from any state, load-use only from RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (w_freeze) begin
         state_d = state_q;
         cnt_d   = cnt_q;
      end else if (w_branch) begin
         state_d = (BR_EXTRA > 0) ? S_BR_SQUASH : S_RUN;
         cnt_d   = (BR_EXTRA > 0) ? C_BR_LOAD : 3'd0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (w_hz && (LU_BUBBLES > 1)) begin
                  state_d = S_LU_WAIT;
                  cnt_d   = C_LU_LOAD;
               end
            end
            S_LU_WAIT, S_BR_SQUASH: begin
               if (cnt_q <= 3'd1) begin
                  state_d = S_RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d   = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = S_RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Control outputs straight from reset, inputs and current state.
   always_comb begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_pipe_freeze = 1'b0;
      if (!reset) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_freeze) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_pipe_freeze = 1'b1;
      end else if (w_branch) begin
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else begin
         case (state_q)
            S_RUN: begin
               if (w_hz) begin
                  w_pc_write   = 1'b0;
                  w_ifid_write = 1'b0;
                  w_idex_flush = 1'b1;
               end
            end
            S_LU_WAIT: begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_idex_flush = 1'b1;
            end
            S_BR_SQUASH: begin
               w_ifid_flush = 1'b1;
            end
            default: begin
               w_pc_write = 1'b1;
            end
         endcase
      end
   end

   // Saturating event counter increments.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!w_pc_write && (stall_cnt_q != C_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (w_branch && (flush_cnt_q != C_CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // Performance counter registers, cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_write_o    = w_pc_write;
   assign bus.ifid_write_o  = w_ifid_write;
   assign bus.ifid_flush_o  = w_ifid_flush;
   assign bus.idex_flush_o  = w_idex_flush;
   assign bus.pipe_freeze_o = w_pipe_freeze;
   assign bus.stall_cnt_o   = stall_cnt_q;
   assign bus.flush_cnt_o   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Two hazard-controller instances with different parameters, fed
//             the same stimulus and compared every cycle to a behavioural
//             model, plus directed sequences with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int A_LU = 1, A_BR = 2, A_CW = 4;
   localparam int B_LU = 3, B_BR = 0, B_CW = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       uses2 = 1'b0, memread = 1'b0, br = 1'b0, mreq = 1'b0, mrdy = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(A_CW)) ia ();
   pipe_hazard_ctrl_if #(.CNT_W(B_CW)) ib ();

   assign ia.id_rs1_i = rs1;            assign ib.id_rs1_i = rs1;
   assign ia.id_rs2_i = rs2;            assign ib.id_rs2_i = rs2;
   assign ia.id_uses_rs2_i = uses2;     assign ib.id_uses_rs2_i = uses2;
   assign ia.ex_rd_i = rd;              assign ib.ex_rd_i = rd;
   assign ia.ex_memread_i = memread;    assign ib.ex_memread_i = memread;
   assign ia.ex_branch_taken_i = br;    assign ib.ex_branch_taken_i = br;
   assign ia.mem_req_i = mreq;          assign ib.mem_req_i = mreq;
   assign ia.mem_ready_i = mrdy;        assign ib.mem_ready_i = mrdy;

   pipe_hazard_ctrl #(.LU_BUBBLES(A_LU), .BR_EXTRA(A_BR), .CNT_W(A_CW)) dut_a (
      .clk(clk), .reset(reset), .bus(ia));
   pipe_hazard_ctrl #(.LU_BUBBLES(B_LU), .BR_EXTRA(B_BR), .CNT_W(B_CW)) dut_b (
      .clk(clk), .reset(reset), .bus(ib));

   wire [4:0] ctrl_a = {ia.pc_write_o, ia.ifid_write_o, ia.ifid_flush_o,
                        ia.idex_flush_o, ia.pipe_freeze_o};
   wire [4:0] ctrl_b = {ib.pc_write_o, ib.ifid_write_o, ib.ifid_flush_o,
                        ib.idex_flush_o, ib.pipe_freeze_o};

   // Output vector encodings {pc_write, ifid_write, ifid_flush, idex_flush, freeze}
   localparam logic [4:0] O_RST = 5'b00110;
   localparam logic [4:0] O_FRZ = 5'b00001;
   localparam logic [4:0] O_BR  = 5'b11110;
   localparam logic [4:0] O_LU  = 5'b00010;
   localparam logic [4:0] O_SQ  = 5'b11100;
   localparam logic [4:0] O_NRM = 5'b11000;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining bubbles and squash cycles as plain integers.
   typedef struct {
      int lu_left;
      int sq_left;
      int stall;
      int flush;
   } mdl_t;

   mdl_t ma = '{0, 0, 0, 0};
   mdl_t mb = '{0, 0, 0, 0};

   function automatic logic [4:0] mdl_step(input int lu_b, input int br_x,
                                           input int cw, inout mdl_t m);
      int mx;
      logic hz;
      logic [4:0] e;
      mx = (1 << cw) - 1;
      hz = memread && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
      if (!reset) return O_RST;
      if (mreq && !mrdy) begin
         e = O_FRZ;
      end else if (br) begin
         e = O_BR;
         m.sq_left = br_x;
         m.lu_left = 0;
         if (m.flush < mx) m.flush++;
      end else if (m.lu_left > 0) begin
         e = O_LU;
         m.lu_left--;
      end else if (m.sq_left > 0) begin
         e = O_SQ;
         m.sq_left--;
      end else if (hz) begin
         e = O_LU;
         m.lu_left = lu_b - 1;
      end else begin
         e = O_NRM;
      end
      if (!e[4] && (m.stall < mx)) m.stall++;
      return e;
   endfunction

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      logic [4:0] ea, eb;
      if (!reset) begin
         ma = '{0, 0, 0, 0};
         mb = '{0, 0, 0, 0};
      end
      chk("a_stall_cnt", int'(ia.stall_cnt_o), ma.stall);
      chk("a_flush_cnt", int'(ia.flush_cnt_o), ma.flush);
      chk("b_stall_cnt", int'(ib.stall_cnt_o), mb.stall);
      chk("b_flush_cnt", int'(ib.flush_cnt_o), mb.flush);
      ea = mdl_step(A_LU, A_BR, A_CW, ma);
      eb = mdl_step(B_LU, B_BR, B_CW, mb);
      chk("a_ctrl", int'(ctrl_a), int'(ea));
      chk("b_ctrl", int'(ctrl_b), int'(eb));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0; uses2 = 1'b0;
      memread = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int bubbles;
      idle();
      #2;
      chk("reset_ctrl_a", int'(ctrl_a), int'(O_RST));
      chk("reset_stall_a", int'(ia.stall_cnt_o), 0);
      step();
      reset = 1'b1;

      // 1: single load-use bubble on instance A
      do_reset();
      memread = 1'b1; rd = 5'd5; rs1 = 5'd5; #1;
      chk("t1_bubble_a", int'(ctrl_a), int'(O_LU));
      step();
      memread = 1'b0; #1;
      chk("t1_normal_a", int'(ctrl_a), int'(O_NRM));
      chk("t1_stall_a", int'(ia.stall_cnt_o), 1);
      step();

      // 2: x0 destination and unused rs2 must not stall
      do_reset();
      memread = 1'b1; rd = 5'd0; rs1 = 5'd0; #1;
      chk("t2_x0_a", int'(ctrl_a), int'(O_NRM));
      step();
      rd = 5'd3; rs1 = 5'd1; rs2 = 5'd3; uses2 = 1'b0; #1;
      chk("t2_rs2_unused_b", int'(ctrl_b), int'(O_NRM));
      step();
      idle(); #1;
      chk("t2_stall_a", int'(ia.stall_cnt_o), 0);
      step();

      // 3: taken branch together with a hazard, then two squash cycles on A
      do_reset();
      br = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5; #1;
      chk("t3_branch_a", int'(ctrl_a), int'(O_BR));
      step();
      idle(); #1;
      chk("t3_squash1_a", int'(ctrl_a), int'(O_SQ));
      step();
      chk("t3_squash2_a", int'(ctrl_a), int'(O_SQ));
      step();
      chk("t3_after_a", int'(ctrl_a), int'(O_NRM));
      chk("t3_flush_a", int'(ia.flush_cnt_o), 1);
      chk("t3_stall_a", int'(ia.stall_cnt_o), 0);
      step();

      // 4: three-bubble load-use interrupted by a three-cycle freeze on B
      do_reset();
      bubbles = 0;
      memread = 1'b1; rd = 5'd7; rs1 = 5'd7; #1;
      if (ctrl_b == O_LU) bubbles++;
      step();
      mreq = 1'b1; mrdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_freeze_b", int'(ctrl_b), int'(O_FRZ));
         step();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ctrl_b == O_LU) bubbles++;
         step();
      end
      chk("t4_bubbles_b", bubbles, 3);
      chk("t4_stall_b", int'(ib.stall_cnt_o), 6);

      // 5: asynchronous reset mid LU_WAIT on B
      do_reset();
      memread = 1'b1; rd = 5'd4; rs1 = 5'd4;
      step();
      memread = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_ctrl_b", int'(ctrl_b), int'(O_RST));
      chk("t5_async_stall_b", int'(ib.stall_cnt_o), 0);
      step();
      reset = 1'b1; #1;
      chk("t5_release_b", int'(ctrl_b), int'(O_NRM));
      step();

      // 6: counter saturation on the narrow instance
      do_reset();
      memread = 1'b1; rd = 5'd9; rs1 = 5'd9;
      for (int i = 0; i < 20; i++) step();
      chk("t6_sat_a", int'(ia.stall_cnt_o), 15);
      chk("t6_b", int'(ib.stall_cnt_o), 20);
      step();
      chk("t6_hold_a", int'(ia.stall_cnt_o), 15);

      // Randomised traffic with small register numbers to force collisions
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rs1     = 5'($urandom_range(0, 3));
         rs2     = 5'($urandom_range(0, 3));
         rd      = 5'($urandom_range(0, 3));
         uses2   = 1'($urandom_range(0, 1));
         memread = 1'($urandom_range(0, 1));
         br      = ($urandom_range(0, 5) == 0);
         mreq    = ($urandom_range(0, 3) == 0);
         mrdy    = 1'($urandom_range(0, 1));
         reset   = ($urandom_range(0, 149) != 0);
         step();
      end
      idle();
      reset = 1'b1;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
